// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port data memory between CPU and EXT ports
//
// Ports:
//   clk, reset_n                        clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata               CPU access request (level, held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata      CPU grant pulse, read-return pulse, held read data
//   cpu_stall                           CPU request waiting for its grant
//   ext_req/we/addr/wdata               loader/readback engine request
//   ext_gnt, ext_rvalid, ext_rdata      loader grant pulse, read-return pulse, held read data
//   mem_en/we/addr/wdata, mem_rdata     registered memory strobe/controls, read data in
//   busy                                an access is in flight (state != IDLE)

`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  // Read-wait counter counts down from RD_LAT-1 to 0.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             last_ext;   // 1: EXT owned the previous access
  logic             win_ext;    // owner of the access currently in flight
  logic [CNT_W-1:0] cnt;
  logic             pick_cpu;
  logic             pick_ext;

  // EXT wins when it is alone, or when both request and the CPU went last.
  always_comb begin
    pick_ext = 1'b0;
    pick_cpu = 1'b0;
    pick_ext = ext_req & (~cpu_req | ~last_ext);
    pick_cpu = cpu_req & ~pick_ext;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_ext   <= 1'b1;
      win_ext    <= 1'b0;
      cnt        <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ext_gnt    <= 1'b0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu || pick_ext) begin
            state     <= ACC;
            win_ext   <= pick_ext;
            cpu_gnt   <= pick_cpu;
            ext_gnt   <= pick_ext;
            mem_en    <= 1'b1;
            mem_we    <= pick_ext ? ext_we    : cpu_we;
            mem_addr  <= pick_ext ? ext_addr  : cpu_addr;
            mem_wdata <= pick_ext ? ext_wdata : cpu_wdata;
          end
        end
        ACC: begin
          // mem_we/addr/wdata deliberately keep their values.
          mem_en   <= 1'b0;
          cpu_gnt  <= 1'b0;
          ext_gnt  <= 1'b0;
          last_ext <= win_ext;
          if (mem_we) begin
            state <= IDLE;
          end else begin
            state <= RD_WAIT;
            cnt   <= CNT_W'(RD_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            // Last wait cycle: mem_rdata is valid now; only the owner's rdata moves.
            state <= IDLE;
            if (win_ext) begin
              ext_rdata  <= mem_rdata;
              ext_rvalid <= 1'b1;
            end else begin
              cpu_rdata  <= mem_rdata;
              cpu_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter

`timescale 1ns/1ps

module tb_dmem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk;
  logic          reset_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 256 words, read data valid two cycles after the mem_en cycle.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_p1 = '0;
  logic [DW-1:0] rd_p2 = '0;
  bit            mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16] <= 16'h1234;
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_en && !mem_we) rd_p1 <= mem[mem_addr[7:0]];
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: kind 0 cpu_gnt, 1 ext_gnt, 2 cpu_rvalid, 3 ext_rvalid.
  typedef struct {
    int            kind;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;
  ev_t sb[$];

  task automatic push(input int kind, input int c, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.we = we; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      if (kind < 2) begin
        chk("mem_en", mem_en, 1);
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", mem_wdata, e.data);
      end else begin
        chk("rdata", (kind == 2) ? cpu_rdata : ext_rdata, e.data);
      end
    end
  endtask

  int last_gnt = -10;
  always @(negedge clk) begin
    if (reset_n) begin
      if (cpu_gnt || ext_gnt) begin
        chk("gnt_spacing", (cyc - last_gnt) > 1, 1);
        last_gnt <= cyc;
      end
      if (cpu_gnt)    check_event(0);
      if (ext_gnt)    check_event(1);
      if (cpu_rvalid) check_event(2);
      if (ext_rvalid) check_event(3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_stall, mem_en, mem_we, busy}, 0);
    chk({tag, "_rdata"}, {cpu_rdata, ext_rdata}, 0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
  endtask

  task automatic wait_gnt(input bit ext, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ext ? ext_gnt : cpu_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL gnt_timeout: got no grant expected grant for port %0d", ext);
    end
  endtask

  task automatic wait_rvalid(input bit ext);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ext ? ext_rvalid : cpu_rvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rvalid_timeout: got no rvalid expected rvalid for port %0d", ext);
    end
  endtask

  // Issued from posedge+1 with the arbiter idle; returns in an IDLE cycle.
  task automatic single(input bit ext, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    bit ok;
    push(ext ? 1 : 0, cyc + 1, we, a, d);
    if (!we) push(ext ? 3 : 2, cyc + 2 + LAT, 1'b0, '0, exp_rd);
    if (ext) begin
      ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    wait_gnt(ext, ok);
    if (ext) ext_req = 1'b0;
    else     cpu_req = 1'b0;
    if (we) tick();
    else    wait_rvalid(ext);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c, ck, ek;

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("init");
    reset_n = 1'b1;
    tick();

    // Reset mid-sim while a CPU write sits in ACC, then a clean CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0007; cpu_wdata = 16'h1111;
    wait_gnt(1'b0, ok);
    cpu_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    single(1'b0, 1'b1, 16'h0005, 16'hABCD, '0);

    // Round robin: CPU went last, so EXT leads; 4 writes each.
    c = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push(1, c + 1 + 2 * i, 1'b1, 16'(16'h0030 + i / 2), 16'(16'hE000 + i / 2));
      else            push(0, c + 1 + 2 * i, 1'b1, 16'(16'h0020 + i / 2), 16'(16'hC000 + i / 2));
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hC000;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0030; ext_wdata = 16'hE000;
    ck = 0;
    ek = 0;
    for (int i = 0; i < 30 && (ck < 4 || ek < 4); i++) begin
      tick();
      if (cpu_gnt) begin
        ck++;
        if (ck == 4) cpu_req = 1'b0;
        else begin
          cpu_addr  = 16'(16'h0020 + ck);
          cpu_wdata = 16'(16'hC000 + ck);
        end
      end
      if (ext_gnt) begin
        ek++;
        if (ek == 4) ext_req = 1'b0;
        else begin
          ext_addr  = 16'(16'h0030 + ek);
          ext_wdata = 16'(16'hE000 + ek);
        end
      end
    end
    chk("rr_grants", {ck[7:0], ek[7:0]}, {8'd4, 8'd4});
    cpu_req = 1'b0;
    ext_req = 1'b0;
    tick();

    // CPU read with RD_LAT=2.
    single(1'b0, 1'b0, 16'h0010, '0, 16'h1234);
    chk("t3_ext_rdata", ext_rdata, 16'h0000);
    repeat (3) tick();
    chk("t3_cpu_hold", cpu_rdata, 16'h1234);

    // CPU stalls behind an EXT read.
    c = cyc;
    push(1, c + 1, 1'b0, 16'h0005, '0);
    push(3, c + 4, 1'b0, '0, 16'hABCD);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0005;
    wait_gnt(1'b1, ok);
    ext_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h4444;
    push(0, c + 5, 1'b1, 16'h0040, 16'h4444);
    #1 chk("t4_stall_rdwait", cpu_stall, 1);
    tick();
    chk("t4_stall_rdwait2", cpu_stall, 1);
    tick();
    chk("t4_ext_rvalid", ext_rvalid, 1);
    chk("t4_stall_rvalid", cpu_stall, 1);
    tick();
    chk("t4_cpu_gnt", cpu_gnt, 1);
    chk("t4_stall_gnt", cpu_stall, 0);
    cpu_req = 1'b0;
    tick();

    // Reset during an EXT read's RD_WAIT.
    c = cyc;
    push(1, c + 1, 1'b0, 16'h0020, '0);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
    wait_gnt(1'b1, ok);
    ext_req = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1 chk("t5_ext_rdata", ext_rdata, 16'h0000);
    chk("t5_busy", busy, 0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rvalid", ext_rvalid, 0);
    end
    single(1'b0, 1'b0, 16'h0040, '0, 16'h4444);

    // Ordering, then a withdrawn EXT request.
    single(1'b1, 1'b1, 16'h0003, 16'h00AA, '0);
    single(1'b0, 1'b0, 16'h0003, '0, 16'h00AA);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0009; ext_wdata = 16'h9999;
    #3 ext_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_gnt", ext_gnt, 0);
      chk("t6_idle", busy, 0);
    end

    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
